// File: rtl/sqrt_input_stage.sv
// sqrt_input_stage
// Input stage and sequencer for the square-root datapath. Accepts one
// {sign, exp, man} operand per request, classifies it, resolves zero /
// negative / infinity / NaN locally, and for normal operands builds the
// aligned radicand and halved exponent, pulses the sqrt core, waits for
// its completion and holds the result metadata until acknowledged.
//
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   run          operand request (sampled only in IDLE)
//   in_float     operand {sign, exp[EXP_W], man[MAN_W]}
//   busy         high whenever not IDLE
//   start_sqrt   one-cycle start pulse to the core
//   radicand     aligned significand for the core (MAN_W+2 bits)
//   sqrt_done    core completion (honoured only in WAIT)
//   out_valid    result metadata valid, held until out_ack
//   out_ack      consumer accepts the result
//   out_class    0 normal, 1 zero, 2 infinity, 3 NaN
//   out_sign     result sign
//   out_exp      biased result exponent (normal class only)
module sqrt_input_stage #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int BIAS  = 2**(EXP_W-1) - 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   run,
    input  logic [EXP_W+MAN_W:0]   in_float,
    output logic                   busy,
    output logic                   start_sqrt,
    output logic [MAN_W+1:0]       radicand,
    input  logic                   sqrt_done,
    output logic                   out_valid,
    input  logic                   out_ack,
    output logic [1:0]             out_class,
    output logic                   out_sign,
    output logic [EXP_W-1:0]       out_exp
);

    localparam int FW = 1 + EXP_W + MAN_W;
    localparam logic [EXP_W:0] BIAS_X = (EXP_W+1)'(BIAS);

    localparam logic [1:0] CLS_NORM = 2'd0;
    localparam logic [1:0] CLS_ZERO = 2'd1;
    localparam logic [1:0] CLS_INF  = 2'd2;
    localparam logic [1:0] CLS_NAN  = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_WAIT,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [FW-1:0]      op_q, op_d;
    logic [MAN_W+1:0]   rad_q, rad_d;
    logic [1:0]         cls_q, cls_d;
    logic               sign_q, sign_d;
    logic [EXP_W-1:0]   exp_q, exp_d;

    // Field decode of the registered operand
    logic               op_sign;
    logic [EXP_W-1:0]   op_exp;
    logic [MAN_W-1:0]   op_man;
    logic               exp_ones, exp_zero, man_zero;

    assign op_sign  = op_q[FW-1];
    assign op_exp   = op_q[MAN_W +: EXP_W];
    assign op_man   = op_q[MAN_W-1:0];
    assign exp_ones = &op_exp;
    assign exp_zero = ~|op_exp;
    assign man_zero = ~|op_man;

    // Unbiased exponent, signed at EXP_W+1 bits (two's complement wrap).
    logic [EXP_W:0]     u;
    logic [EXP_W-1:0]   res_exp;
    logic [MAN_W+1:0]   rad_norm;

    assign u = {1'b0, op_exp} - BIAS_X;

    // For odd u the significand is doubled and u decremented; floor((u-1)/2)
    // equals floor(u/2) for odd u, so the halved exponent is simply u >>> 1
    // in both cases, i.e. bits [EXP_W:1] after truncation to EXP_W.
    assign res_exp  = u[EXP_W:1] + BIAS_X[EXP_W-1:0];
    assign rad_norm = u[0] ? {1'b1, op_man, 1'b0} : {2'b01, op_man};

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        rad_d   = rad_q;
        cls_d   = cls_q;
        sign_d  = sign_q;
        exp_d   = exp_q;
        case (state_q)
            S_IDLE: begin
                if (run) begin
                    op_d    = in_float;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                exp_d   = '0;
                sign_d  = 1'b0;
                state_d = S_DONE;
                if (exp_ones) begin
                    cls_d = (!man_zero || op_sign) ? CLS_NAN : CLS_INF;
                end else if (exp_zero) begin
                    // subnormals flush to zero, keeping the input sign
                    cls_d  = CLS_ZERO;
                    sign_d = op_sign;
                end else if (op_sign) begin
                    cls_d = CLS_NAN;
                end else begin
                    cls_d   = CLS_NORM;
                    exp_d   = res_exp;
                    rad_d   = rad_norm;
                    state_d = S_START;
                end
            end
            S_START: state_d = S_WAIT;
            S_WAIT: begin
                if (sqrt_done) state_d = S_DONE;
            end
            S_DONE: begin
                if (out_ack) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            rad_q   <= '0;
            cls_q   <= CLS_NORM;
            sign_q  <= 1'b0;
            exp_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            rad_q   <= rad_d;
            cls_q   <= cls_d;
            sign_q  <= sign_d;
            exp_q   <= exp_d;
        end
    end

    assign busy       = (state_q != S_IDLE);
    assign start_sqrt = (state_q == S_START);
    assign out_valid  = (state_q == S_DONE);
    assign radicand   = rad_q;
    assign out_class  = cls_q;
    assign out_sign   = sign_q;
    assign out_exp    = exp_q;

endmodule

// File: tb/tb_sqrt_input_stage.sv
// Testbench for sqrt_input_stage: directed operands, a behavioural
// float-classification model, and a per-cycle compare process.
module tb_sqrt_input_stage;

    localparam int EXP_W = 8;
    localparam int MAN_W = 23;

    logic                 clk = 1'b0;
    logic                 rst, run, sqrt_done, out_ack;
    logic [31:0]          in_float;
    logic                 busy, start_sqrt, out_valid, out_sign;
    logic [MAN_W+1:0]     radicand;
    logic [1:0]           out_class;
    logic [EXP_W-1:0]     out_exp;

    sqrt_input_stage #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
        .clk(clk), .rst(rst), .run(run), .in_float(in_float),
        .busy(busy), .start_sqrt(start_sqrt), .radicand(radicand),
        .sqrt_done(sqrt_done), .out_valid(out_valid), .out_ack(out_ack),
        .out_class(out_class), .out_sign(out_sign), .out_exp(out_exp)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    logic [31:0] cur_op = 32'h0;

    typedef struct {
        int cls;
        bit sgn_known;
        int sgn;
        int ex;
        int rad;
    } exp_t;

    // Expected result of a square root operand, from plain float arithmetic.
    function automatic exp_t model(input logic [31:0] f);
        exp_t r;
        int e, m, s, u;
        e = int'(f[30:23]);
        m = int'(f[22:0]);
        s = int'(f[31]);
        r.cls = 0; r.sgn_known = 1'b1; r.sgn = 0; r.ex = 0; r.rad = 0;
        if (e == 255) begin
            r.cls = (m != 0 || s != 0) ? 3 : 2;
            r.sgn_known = (r.cls == 2);
        end else if (e == 0) begin
            r.cls = 1;
            r.sgn = s;
        end else if (s != 0) begin
            r.cls = 3;
        end else begin
            u = e - 127;
            if (u % 2 != 0) begin
                r.rad = (m + (1 << 23)) * 2;
                r.ex  = (u - 1) / 2 + 127;
            end else begin
                r.rad = m + (1 << 23);
                r.ex  = u / 2 + 127;
            end
        end
        return r;
    endfunction

    task automatic chk(input string nm, input int act, input int expv);
        n_chk++;
        if (act == expv) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, expv, expv);
    endtask

    // Data check on every cycle the outputs carry meaning.
    always @(negedge clk) begin
        exp_t mm;
        if (!rst) begin
            mm = model(cur_op);
            if (out_valid) begin
                chk("cmp_class", int'(out_class), mm.cls);
                if (mm.sgn_known) chk("cmp_sign", int'(out_sign), mm.sgn);
                if (mm.cls == 0) begin
                    chk("cmp_exp", int'(out_exp), mm.ex);
                    chk("cmp_rad_done", int'(radicand), mm.rad);
                end
            end
            if (start_sqrt) chk("cmp_rad_start", int'(radicand), mm.rad);
        end
    end

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_busy"},  int'(busy), 0);
        chk({tag, "_start"}, int'(start_sqrt), 0);
        chk({tag, "_valid"}, int'(out_valid), 0);
        chk({tag, "_class"}, int'(out_class), 0);
        chk({tag, "_sign"},  int'(out_sign), 0);
        chk({tag, "_exp"},   int'(out_exp), 0);
        chk({tag, "_rad"},   int'(radicand), 0);
    endtask

    // One full operation, entered and left at a negedge in IDLE.
    task automatic do_op(input logic [31:0] f, input int wcyc, input int hold,
                         input bit stray, input bit toggle,
                         input int lit_cls, input int lit_sign,
                         input int lit_exp, input int lit_rad);
        exp_t m;
        m = model(f);
        chk("idle_busy", int'(busy), 0);
        cur_op = f; in_float = f; run = 1'b1;
        @(negedge clk);
        run = 1'b0; in_float = 32'hDEADBEEF;
        chk("load_busy", int'(busy), 1);
        chk("load_valid", int'(out_valid), 0);
        chk("load_start", int'(start_sqrt), 0);
        @(negedge clk);
        if (m.cls != 0) begin
            chk("sp_valid", int'(out_valid), 1);
            chk("sp_start", int'(start_sqrt), 0);
        end else begin
            chk("start_pulse", int'(start_sqrt), 1);
            chk("start_valid", int'(out_valid), 0);
            sqrt_done = stray;
            @(negedge clk);
            sqrt_done = 1'b0;
            chk("wait_start_low", int'(start_sqrt), 0);
            for (int i = 0; i < wcyc; i++) begin
                chk("wait_valid", int'(out_valid), 0);
                chk("wait_busy", int'(busy), 1);
                if (toggle) run = ~run;
                @(negedge clk);
            end
            sqrt_done = 1'b1;
            @(negedge clk);
            sqrt_done = 1'b0;
            chk("done_valid", int'(out_valid), 1);
        end
        if (lit_cls  >= 0) chk("lit_class", int'(out_class), lit_cls);
        if (lit_sign >= 0) chk("lit_sign", int'(out_sign), lit_sign);
        if (lit_exp  >= 0) chk("lit_exp", int'(out_exp), lit_exp);
        if (lit_rad  >= 0) chk("lit_rad", int'(radicand), lit_rad);
        for (int i = 0; i < hold; i++) begin
            if (toggle) run = ~run;
            @(negedge clk);
            chk("hold_valid", int'(out_valid), 1);
            chk("hold_busy", int'(busy), 1);
            chk("hold_start", int'(start_sqrt), 0);
        end
        out_ack = 1'b1;
        if (toggle) run = 1'b1;
        @(negedge clk);
        out_ack = 1'b0; run = 1'b0;
        chk("ack_valid", int'(out_valid), 0);
        chk("ack_busy", int'(busy), 0);
        @(negedge clk);
        chk("idle_stays", int'(busy), 0);
    endtask

    logic [31:0] sp_ops [5] = '{32'hC0800000, 32'h80000000, 32'h7F800000,
                                32'h7FC00000, 32'h00000001};
    int          sp_cls [5] = '{3, 1, 2, 3, 1};
    int          sp_sgn [5] = '{0, 1, 0, -1, 0};

    initial begin
        exp_t pm;
        rst = 1'b1; run = 1'b0; sqrt_done = 1'b0; out_ack = 1'b0; in_float = 32'h0;
        repeat (2) @(negedge clk);
        chk_reset_vals("reset");
        rst = 1'b0;
        @(negedge clk);

        // pin the model against hand-computed values
        pm = model(32'h40800000); chk("model_4p0_exp", pm.ex, 128); chk("model_4p0_rad", pm.rad, 'h800000);
        pm = model(32'h40000000); chk("model_2p0_exp", pm.ex, 127); chk("model_2p0_rad", pm.rad, 'h1000000);
        pm = model(32'h3F000000); chk("model_0p5_exp", pm.ex, 126);
        pm = model(32'h80000000); chk("model_m0_cls", pm.cls, 1);   chk("model_m0_sign", pm.sgn, 1);

        // stray sqrt_done in IDLE
        sqrt_done = 1'b1;
        @(negedge clk);
        sqrt_done = 1'b0;
        chk("stray_idle_busy", int'(busy), 0);
        chk("stray_idle_valid", int'(out_valid), 0);

        do_op(32'h40800000, 5, 3, 1'b0, 1'b0, 0, 0, 128, 'h800000);
        do_op(32'h40000000, 1, 0, 1'b0, 1'b0, 0, 0, 127, 'h1000000);
        do_op(32'h3F000000, 0, 0, 1'b0, 1'b0, 0, 0, 126, 'h1000000);
        for (int i = 0; i < 5; i++)
            do_op(sp_ops[i], 0, 1, 1'b0, 1'b0, sp_cls[i], sp_sgn[i], -1, -1);

        // stray sqrt_done in START, run toggling in WAIT and DONE
        do_op(32'h40800000, 3, 2, 1'b1, 1'b1, 0, 0, 128, 'h800000);

        // reset while in WAIT
        cur_op = 32'h40800000; in_float = 32'h40800000; run = 1'b1;
        @(negedge clk); run = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("pre_rst_busy", int'(busy), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_reset_vals("wait_rst");
        sqrt_done = 1'b1;
        @(negedge clk);
        sqrt_done = 1'b0;
        chk("late_done_valid", int'(out_valid), 0);
        chk("late_done_busy", int'(busy), 0);
        @(negedge clk);
        chk("late_done_valid2", int'(out_valid), 0);
        do_op(32'h40800000, 2, 0, 1'b0, 1'b0, 0, 0, 128, 'h800000);

        // back to back: IDLE, LOAD, START, WAIT, DONE repeating every 5 cycles
        cur_op = 32'h40800000; in_float = 32'h40800000;
        run = 1'b1; out_ack = 1'b1; sqrt_done = 1'b1;
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            chk("b2b_busy",  int'(busy),       (k % 5 != 0) ? 1 : 0);
            chk("b2b_valid", int'(out_valid),  (k % 5 == 4) ? 1 : 0);
            chk("b2b_start", int'(start_sqrt), (k % 5 == 2) ? 1 : 0);
        end
        run = 1'b0; out_ack = 1'b0; sqrt_done = 1'b0;
        @(negedge clk);
        chk("b2b_end_busy", int'(busy), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
